// File: rtl/iq_issue_scheduler.sv
// rtl/iq_issue_scheduler.sv - wakeup/select instruction queue with age-ordered issue and count-based flush
module iq_issue_scheduler #(
  parameter int IQ_DEPTH = 8,
  parameter int PREG_W   = 6,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [PREG_W-1:0]         alloc_rs_phys,
  input  logic [PREG_W-1:0]         alloc_rt_phys,
  input  logic [PREG_W-1:0]         alloc_rw_phys,
  input  logic                      alloc_uses_rs,
  input  logic                      alloc_uses_rt,
  input  logic                      alloc_rs_rdy,
  input  logic                      alloc_rt_rdy,
  input  logic [CNT_W-1:0]          alloc_count,
  input  logic                      wb0_valid,
  input  logic [PREG_W-1:0]         wb0_phys,
  input  logic                      wb1_valid,
  input  logic [PREG_W-1:0]         wb1_phys,
  input  logic                      flush,
  input  logic [CNT_W-1:0]          flush_count,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [PREG_W-1:0]         issue_rs_phys,
  output logic [PREG_W-1:0]         issue_rt_phys,
  output logic [PREG_W-1:0]         issue_rw_phys,
  output logic [CNT_W-1:0]          issue_count,
  output logic [$clog2(IQ_DEPTH):0] occupancy
);
  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [IQ_DEPTH-1:0] r_valid, r_rs_rdy, r_rt_rdy;
  logic [PREG_W-1:0]   r_rs [IQ_DEPTH];
  logic [PREG_W-1:0]   r_rt [IQ_DEPTH];
  logic [PREG_W-1:0]   r_rw [IQ_DEPTH];
  logic [CNT_W-1:0]    r_cnt [IQ_DEPTH];

  logic                r_issue_valid;
  logic [PREG_W-1:0]   r_issue_rs, r_issue_rt, r_issue_rw;
  logic [CNT_W-1:0]    r_issue_cnt;

  logic [IQ_DEPTH-1:0] w_slot_rdy, w_flush_kill;
  logic                w_any_rdy, w_found_free;
  logic [IDX_W-1:0]    w_sel, w_free;
  logic [OCC_W-1:0]    w_occ;
  logic                w_alloc_fire, w_issue_load;

  // Wrap-safe age: a is older than b when (a - b) is negative at CNT_W bits.
  function automatic logic older(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] d;
    d = a - b;
    return d[CNT_W-1];
  endfunction

  function automatic logic younger(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] d;
    d = a - b;
    return !d[CNT_W-1] && (d != '0);
  endfunction

  function automatic logic wake(input logic [PREG_W-1:0] tag);
    return (wb0_valid && (wb0_phys == tag)) || (wb1_valid && (wb1_phys == tag));
  endfunction

  always_comb begin
    w_slot_rdy   = '0;
    w_flush_kill = '0;
    w_any_rdy    = 1'b0;
    w_sel        = '0;
    w_found_free = 1'b0;
    w_free       = '0;
    w_occ        = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      w_slot_rdy[i]   = r_valid[i] && r_rs_rdy[i] && r_rt_rdy[i];
      w_flush_kill[i] = r_valid[i] && younger(r_cnt[i], flush_count);
      w_occ           = w_occ + OCC_W'(r_valid[i]);
      // Strictly-older test keeps the lower index on an (illegal) count tie.
      if (w_slot_rdy[i] && (!w_any_rdy || older(r_cnt[i], r_cnt[w_sel]))) begin
        w_any_rdy = 1'b1;
        w_sel     = IDX_W'(i);
      end
      if (!r_valid[i] && !w_found_free) begin
        w_found_free = 1'b1;
        w_free       = IDX_W'(i);
      end
    end
  end

  assign occupancy    = w_occ;
  assign alloc_ready  = !rst && (w_occ < OCC_W'(IQ_DEPTH));
  assign w_alloc_fire = alloc_valid && alloc_ready && !flush;
  assign w_issue_load = !flush && w_any_rdy && (!r_issue_valid || issue_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_rs_rdy <= '0;
      r_rt_rdy <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        r_rs[i]  <= '0;
        r_rt[i]  <= '0;
        r_rw[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (r_valid[i]) begin
          if (wake(r_rs[i])) r_rs_rdy[i] <= 1'b1;
          if (wake(r_rt[i])) r_rt_rdy[i] <= 1'b1;
        end
        if (flush && w_flush_kill[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_issue_load && (w_sel == IDX_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (w_alloc_fire && (w_free == IDX_W'(i))) begin
          r_valid[i]  <= 1'b1;
          r_rs[i]     <= alloc_rs_phys;
          r_rt[i]     <= alloc_rt_phys;
          r_rw[i]     <= alloc_rw_phys;
          r_cnt[i]    <= alloc_count;
          r_rs_rdy[i] <= !alloc_uses_rs || alloc_rs_rdy || wake(alloc_rs_phys);
          r_rt_rdy[i] <= !alloc_uses_rt || alloc_rt_rdy || wake(alloc_rt_phys);
        end
      end
    end
  end

  // A surviving entry accepted during a flush still retires; no refill that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_valid <= 1'b0;
      r_issue_rs    <= '0;
      r_issue_rt    <= '0;
      r_issue_rw    <= '0;
      r_issue_cnt   <= '0;
    end else if (flush) begin
      if (r_issue_valid && (younger(r_issue_cnt, flush_count) || issue_ready))
        r_issue_valid <= 1'b0;
    end else if (w_issue_load) begin
      r_issue_valid <= 1'b1;
      r_issue_rs    <= r_rs[w_sel];
      r_issue_rt    <= r_rt[w_sel];
      r_issue_rw    <= r_rw[w_sel];
      r_issue_cnt   <= r_cnt[w_sel];
    end else if (issue_ready) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_rs_phys = r_issue_rs;
  assign issue_rt_phys = r_issue_rt;
  assign issue_rw_phys = r_issue_rw;
  assign issue_count   = r_issue_cnt;
endmodule

// File: tb/tb_iq_issue_scheduler.sv
// tb/tb_iq_issue_scheduler.sv - self-checking bench for iq_issue_scheduler
module tb_iq_issue_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [5:0]  alloc_rs_phys = '0, alloc_rt_phys = '0, alloc_rw_phys = '0;
  logic        alloc_uses_rs = 1'b0, alloc_uses_rt = 1'b0;
  logic        alloc_rs_rdy = 1'b0, alloc_rt_rdy = 1'b0;
  logic [31:0] alloc_count = '0;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [5:0]  wb0_phys = '0, wb1_phys = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_count = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [5:0]  issue_rs_phys, issue_rt_phys, issue_rw_phys;
  logic [31:0] issue_count;
  logic [3:0]  occupancy;

  iq_issue_scheduler #(.IQ_DEPTH(8), .PREG_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rs_phys(alloc_rs_phys), .alloc_rt_phys(alloc_rt_phys), .alloc_rw_phys(alloc_rw_phys),
    .alloc_uses_rs(alloc_uses_rs), .alloc_uses_rt(alloc_uses_rt),
    .alloc_rs_rdy(alloc_rs_rdy), .alloc_rt_rdy(alloc_rt_rdy), .alloc_count(alloc_count),
    .wb0_valid(wb0_valid), .wb0_phys(wb0_phys), .wb1_valid(wb1_valid), .wb1_phys(wb1_phys),
    .flush(flush), .flush_count(flush_count),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_phys(issue_rs_phys), .issue_rt_phys(issue_rt_phys), .issue_rw_phys(issue_rw_phys),
    .issue_count(issue_count), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [5:0]  rw;
  } exp_t;

  typedef struct {
    logic        av;
    logic [31:0] cnt;
    logic [5:0]  rw;
    logic        exp_iv;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_occ;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[6];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Accepted issues are compared against the scoreboard in program order.
  task automatic mon();
    exp_t e;
    if (issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", issue_count);
      end else begin
        e = exp_q.pop_front();
        chk("sb_count", 64'(issue_count), 64'(e.cnt));
        chk("sb_rw", 64'(issue_rw_phys), 64'(e.rw));
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    wb0_valid   = 1'b0;
    wb1_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drive_alloc(input logic [31:0] c, input logic [5:0] rs, input logic [5:0] rt,
                             input logic [5:0] rw, input logic urs, input logic rrs,
                             input logic urt, input logic rrt);
    alloc_valid   = 1'b1;
    alloc_count   = c;
    alloc_rs_phys = rs;
    alloc_rt_phys = rt;
    alloc_rw_phys = rw;
    alloc_uses_rs = urs;
    alloc_rs_rdy  = rrs;
    alloc_uses_rt = urt;
    alloc_rt_rdy  = rrt;
  endtask

  task automatic push(input logic [31:0] c, input logic [5:0] rw);
    exp_t e;
    e.cnt = c;
    e.rw  = rw;
    exp_q.push_back(e);
  endtask

  initial begin
    vt[0] = '{1'b1, 32'd10, 6'd1, 1'b0, 32'd0,  4'd0};
    vt[1] = '{1'b1, 32'd11, 6'd2, 1'b0, 32'd0,  4'd1};
    vt[2] = '{1'b1, 32'd12, 6'd3, 1'b1, 32'd10, 4'd1};
    vt[3] = '{1'b0, 32'd0,  6'd0, 1'b1, 32'd11, 4'd1};
    vt[4] = '{1'b0, 32'd0,  6'd0, 1'b1, 32'd12, 4'd0};
    vt[5] = '{1'b0, 32'd0,  6'd0, 1'b0, 32'd0,  4'd0};

    #1 rst = 1'b1;
    #12;
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_issue_count", 64'(issue_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sample();
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    step();

    // In-order issue of three ready instructions, one vector per cycle.
    issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (vt[i].av) begin
        drive_alloc(vt[i].cnt, 6'd0, 6'd0, vt[i].rw, 1'b0, 1'b0, 1'b0, 1'b0);
        push(vt[i].cnt, vt[i].rw);
      end
      sample();
      chk("t_issue_valid", 64'(issue_valid), 64'(vt[i].exp_iv));
      if (vt[i].exp_iv) chk("t_issue_count", 64'(issue_count), 64'(vt[i].exp_cnt));
      chk("t_occupancy", 64'(occupancy), 64'(vt[i].exp_occ));
      step();
    end

    // Younger ready instruction bypasses an older one waiting on a wakeup.
    drive_alloc(32'd5, 6'd7, 6'd0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'd6, 6'd8, 6'd0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    wb0_valid = 1'b1;
    wb0_phys  = 6'd7;
    push(32'd6, 6'd6);
    push(32'd5, 6'd5);
    sample();
    chk("wk_iv_early", 64'(issue_valid), 64'd0);
    step();
    idle();
    sample();
    chk("wk_first", 64'(issue_count), 64'd6);
    step();
    sample();
    chk("wk_second_iv", 64'(issue_valid), 64'd1);
    chk("wk_second", 64'(issue_count), 64'd5);
    step();
    sample();
    chk("wk_drain_iv", 64'(issue_valid), 64'd0);
    step();

    // Same-cycle writeback bypass on the allocating source.
    drive_alloc(32'd30, 6'd0, 6'd9, 6'd30, 1'b0, 1'b0, 1'b1, 1'b0);
    wb1_valid = 1'b1;
    wb1_phys  = 6'd9;
    push(32'd30, 6'd30);
    cyc();
    idle();
    sample();
    chk("byp_iv_early", 64'(issue_valid), 64'd0);
    step();
    sample();
    chk("byp_iv", 64'(issue_valid), 64'd1);
    chk("byp_count", 64'(issue_count), 64'd30);
    step();
    sample();
    chk("byp_drain", 64'(issue_valid), 64'd0);
    step();

    // Fill to capacity, drop a ninth alloc, then stall one woken issue.
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_alloc(32'd40 + 32'(i), 6'(10 + i), 6'd0, 6'(40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    idle();
    sample();
    chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("full_occupancy", 64'(occupancy), 64'd8);
    step();
    drive_alloc(32'd48, 6'd0, 6'd0, 6'd48, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    sample();
    chk("full_drop_occ", 64'(occupancy), 64'd8);
    chk("full_iv", 64'(issue_valid), 64'd0);
    step();
    wb0_valid = 1'b1;
    wb0_phys  = 6'd12;
    push(32'd42, 6'd42);
    cyc();
    idle();
    cyc();
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("stall_iv", 64'(issue_valid), 64'd1);
      chk("stall_count", 64'(issue_count), 64'd42);
      chk("stall_rs", 64'(issue_rs_phys), 64'd12);
      chk("stall_occ", 64'(occupancy), 64'd7);
      step();
    end
    issue_ready = 1'b1;
    cyc();
    sample();
    chk("stall_release_iv", 64'(issue_valid), 64'd0);
    step();
    flush       = 1'b1;
    flush_count = 32'd39;
    cyc();
    idle();
    sample();
    chk("flush_all_occ", 64'(occupancy), 64'd0);
    step();

    // Flush by count with a younger instruction held in the issue register.
    issue_ready = 1'b0;
    drive_alloc(32'd23, 6'd0, 6'd0, 6'd23, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'd20, 6'd20, 6'd0, 6'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'd21, 6'd20, 6'd0, 6'd21, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'd22, 6'd20, 6'd0, 6'd22, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'd24, 6'd20, 6'd0, 6'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'd25, 6'd20, 6'd0, 6'd25, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    flush       = 1'b1;
    flush_count = 32'd21;
    sample();
    chk("fl_pre_count", 64'(issue_count), 64'd23);
    chk("fl_pre_occ", 64'(occupancy), 64'd5);
    step();
    idle();
    issue_ready = 1'b1;
    wb0_valid   = 1'b1;
    wb0_phys    = 6'd20;
    push(32'd20, 6'd20);
    push(32'd21, 6'd21);
    sample();
    chk("fl_iv", 64'(issue_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd2);
    step();
    idle();
    cyc();
    sample();
    chk("fl_first", 64'(issue_count), 64'd20);
    step();
    sample();
    chk("fl_second", 64'(issue_count), 64'd21);
    step();
    sample();
    chk("fl_drain_occ", 64'(occupancy), 64'd0);
    step();

    // Wrap-safe age ordering, then asynchronous reset mid-burst.
    drive_alloc(32'h00000001, 6'd33, 6'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_alloc(32'hFFFFFFFE, 6'd33, 6'd0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    wb0_valid = 1'b1;
    wb0_phys  = 6'd33;
    push(32'hFFFFFFFE, 6'd2);
    push(32'h00000001, 6'd1);
    cyc();
    idle();
    drive_alloc(32'd2, 6'd40, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    sample();
    chk("wrap_first", 64'(issue_count), 64'hFFFFFFFE);
    step();
    issue_ready = 1'b0;
    sample();
    chk("wrap_second", 64'(issue_count), 64'h00000001);
    chk("wrap_occ", 64'(occupancy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_iv", 64'(issue_valid), 64'd0);
    chk("arst_count", 64'(issue_count), 64'd0);
    chk("arst_tags", 64'({issue_rs_phys, issue_rt_phys, issue_rw_phys}), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_alloc_ready", 64'(alloc_ready), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    sample();
    chk("post_rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("post_rst_iv", 64'(issue_valid), 64'd0);
    step();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
